// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-back path.
// Nothing here holds state: it carries the default address/data widths,
// the architectural register count, the hardwired-zero register address and
// the fixed requester slot assignments used by the write-back producers.
package rf_pkg;

  localparam int RF_AW        = 5;
  localparam int RF_DW        = 32;
  localparam int RF_NREGS     = 32;
  localparam int RF_ZERO_ADDR = 0;

  // Requester slot assignments on the write-back arbiter.
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

  typedef logic [RF_NREGS-1:0] busy_vec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over N requesters.
//   clk, nrst : clock, synchronous active-low reset
//   valid     : request vector
//   advance   : a grant was consumed this cycle; pointer moves to the winner
//   grant     : one-hot grant (combinational), only ever on a valid bit
//   ptr       : index of the most recently granted requester
// The search starts at ptr+1 and wraps, so the last winner has the lowest
// priority. The pointer resets to N-1, which gives requester 0 first pick.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [N-1:0]  valid,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    win   = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr_q) + k) % N);
      if (!found && valid[cand]) begin
        grant[cand] = 1'b1;
        win         = cand;
        found       = 1'b1;
      end
    end
    ptr_d = advance ? win : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      ptr_q <= PW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
//   clk, nrst          : clock, synchronous active-low reset
//   req_valid/ready    : per-requester handshake, ready is a one-hot grant
//   req_addr/req_data  : packed per-requester destination and data
//   rf_wr_en/addr/data : registered write port, one cycle after acceptance
//   rf_wr_src          : requester whose beat is currently on the write port
//   busy_set_en/addr   : issue logic reserving a destination register
//   busy_mask          : registers with a write still outstanding
//   x0_drop            : sticky flag, a write to register 0 was discarded
// The port never back-pressures: grants depend only on requests and the
// round-robin pointer.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_wr_en,
  output logic [AW-1:0]      rf_wr_addr,
  output logic [DW-1:0]      rf_wr_data,
  output logic [2:0]         rf_wr_src,
  input  logic               busy_set_en,
  input  logic [AW-1:0]      busy_set_addr,
  output logic [31:0]        busy_mask,
  output logic               x0_drop
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  generate
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("rf_wb_arbiter: NREQ must be in 2..8 to fit rf_wr_src");
    end
  endgenerate

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   ptr;
  logic            xfer;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk     (clk),
    .nrst    (nrst),
    .valid   (req_valid),
    .advance (xfer),
    .grant   (grant),
    .ptr     (ptr)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  // Granted beat's payload; grant is one-hot so OR-ing is a clean mux.
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr[i*AW +: AW];
        sel_data = sel_data | req_data[i*DW +: DW];
      end
    end
  end

  logic            wr_en_q,   wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            src_ok_q,  src_ok_d;
  logic            x0_drop_q, x0_drop_d;
  busy_vec_t       busy_q,    busy_d;
  logic            sel_is_x0;

  assign sel_is_x0 = (sel_addr == AW'(RF_ZERO_ADDR));

  always_comb begin
    wr_en_d   = xfer && !sel_is_x0;
    wr_addr_d = wr_en_d ? sel_addr : wr_addr_q;
    wr_data_d = wr_en_d ? sel_data : wr_data_q;
    src_ok_d  = src_ok_q | xfer;
    x0_drop_d = x0_drop_q | (xfer && sel_is_x0);
  end

  // Scoreboard: a new reservation beats the commit clearing the same bit,
  // because it belongs to a younger producer. Bit 0 never gets set.
  assign busy_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < RF_NREGS; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      assign set_hit    = busy_set_en && (busy_set_addr == AW'(gi));
      assign clr_hit    = wr_en_q && (wr_addr_q == AW'(gi));
      assign busy_d[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_q[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      src_ok_q  <= 1'b0;
      x0_drop_q <= 1'b0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      src_ok_q  <= src_ok_d;
      x0_drop_q <= x0_drop_d;
      busy_q    <= busy_d;
    end
  end

  // The arbiter pointer already holds the last granted index, which is the
  // source of the beat in the output stage. Until the first transfer after
  // reset it still reads NREQ-1, so report 0 instead.
  assign rf_wr_src  = src_ok_q ? 3'(ptr) : 3'd0;
  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign busy_mask  = busy_q;
  assign x0_drop    = x0_drop_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               nrst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rf_wr_en;
  logic [AW-1:0]      rf_wr_addr;
  logic [DW-1:0]      rf_wr_data;
  logic [2:0]         rf_wr_src;
  logic               busy_set_en;
  logic [AW-1:0]      busy_set_addr;
  logic [31:0]        busy_mask;
  logic               x0_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_data    (rf_wr_data),
    .rf_wr_src     (rf_wr_src),
    .busy_set_en   (busy_set_en),
    .busy_set_addr (busy_set_addr),
    .busy_mask     (busy_mask),
    .x0_drop       (x0_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst          = 1'b0;
    req_valid     = '0;
    req_addr      = '0;
    req_data      = '0;
    busy_set_en   = 1'b0;
    busy_set_addr = '0;

    // Reset state
    tick();
    tick();
    check("rst_wr_en",   {31'd0, rf_wr_en}, 32'd0);
    check("rst_wr_addr", {27'd0, rf_wr_addr}, 32'd0);
    check("rst_wr_data", rf_wr_data, 32'd0);
    check("rst_wr_src",  {29'd0, rf_wr_src}, 32'd0);
    check("rst_busy",    busy_mask, 32'd0);
    check("rst_x0",      {31'd0, x0_drop}, 32'd0);
    check("rst_ready",   {29'd0, req_ready}, 32'd0);
    nrst = 1'b1;
    tick();

    // Single requester
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd5};
    req_data  = {32'd0, 32'd0, 32'hDEADBEEF};
    #1;
    check("single_ready", {29'd0, req_ready}, 32'b001);
    tick();
    req_valid = 3'b000;
    check("single_en",   {31'd0, rf_wr_en}, 32'd1);
    check("single_addr", {27'd0, rf_wr_addr}, 32'd5);
    check("single_data", rf_wr_data, 32'hDEADBEEF);
    check("single_src",  {29'd0, rf_wr_src}, 32'd0);
    tick();
    check("single_idle_en",   {31'd0, rf_wr_en}, 32'd0);
    check("single_hold_addr", {27'd0, rf_wr_addr}, 32'd5);
    $display("txn single: addr=5 data=deadbeef src=0");

    // Fresh reset, then all three valid for 6 cycles
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hA2, 32'hA1, 32'hA0};
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_ready", {29'd0, req_ready}, 32'(1 << (c % 3)));
      tick();
      check("rr_en",   {31'd0, rf_wr_en}, 32'd1);
      check("rr_src",  {29'd0, rf_wr_src}, 32'(c % 3));
      check("rr_addr", {27'd0, rf_wr_addr}, 32'(c % 3 + 1));
      check("rr_data", rf_wr_data, 32'hA0 + 32'(c % 3));
      $display("txn rr: cycle=%0d src=%0d addr=%0d", c, rf_wr_src, rf_wr_addr);
    end
    req_valid = 3'b000;
    tick();
    check("rr_end_en", {31'd0, rf_wr_en}, 32'd0);

    // Pointer hold: grant 2, idle 3 cycles, then all valid -> 0
    req_valid = 3'b100;
    #1;
    check("hold_ready2", {29'd0, req_ready}, 32'b100);
    tick();
    req_valid = 3'b000;
    tick();
    tick();
    tick();
    req_valid = 3'b111;
    #1;
    check("hold_ready0", {29'd0, req_ready}, 32'b001);
    tick();
    req_valid = 3'b000;
    check("hold_src0", {29'd0, rf_wr_src}, 32'd0);
    tick();
    $display("txn hold: wrap grant to 0");

    // Write to x0 from requester 1
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd0, 5'd0};
    req_data  = {32'd0, 32'h1234, 32'd0};
    #1;
    check("x0_ready", {29'd0, req_ready}, 32'b010);
    tick();
    req_valid = 3'b000;
    check("x0_en",   {31'd0, rf_wr_en}, 32'd0);
    check("x0_flag", {31'd0, x0_drop}, 32'd1);
    check("x0_busy", busy_mask, 32'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("x0_sticky", {31'd0, x0_drop}, 32'd1);
      check("x0_idle_en", {31'd0, rf_wr_en}, 32'd0);
    end
    $display("txn x0: dropped, flag sticky");

    // Scoreboard set / clear
    busy_set_en   = 1'b1;
    busy_set_addr = 5'd7;
    tick();
    busy_set_en = 1'b0;
    check("sb_set", busy_mask, 32'h80);
    req_valid = 3'b100;
    req_addr  = {5'd7, 5'd0, 5'd0};
    req_data  = {32'h77, 32'd0, 32'd0};
    #1;
    check("sb_ready", {29'd0, req_ready}, 32'b100);
    tick();
    req_valid = 3'b000;
    check("sb_wr_en",     {31'd0, rf_wr_en}, 32'd1);
    check("sb_wr_src",    {29'd0, rf_wr_src}, 32'd2);
    check("sb_pre_clear", busy_mask, 32'h80);
    tick();
    check("sb_cleared", busy_mask, 32'h0);
    check("sb_clr_idle", {31'd0, rf_wr_en}, 32'd0);
    $display("txn sb: set 7, commit 7 clears");

    // Set and clear on the same edge: set wins
    busy_set_en   = 1'b1;
    busy_set_addr = 5'd7;
    tick();
    busy_set_en = 1'b0;
    check("sb_reset7", busy_mask, 32'h80);
    req_valid = 3'b100;
    tick();
    req_valid = 3'b000;
    check("sb2_wr_en", {31'd0, rf_wr_en}, 32'd1);
    busy_set_en   = 1'b1;
    busy_set_addr = 5'd7;
    tick();
    busy_set_en = 1'b0;
    check("sb_set_wins", busy_mask, 32'h80);

    // Reservation of register 0 is ignored
    busy_set_en   = 1'b1;
    busy_set_addr = 5'd0;
    tick();
    busy_set_en = 1'b0;
    check("sb_x0_ignored", busy_mask, 32'h80);
    $display("txn sb: same-edge set wins, x0 set ignored");

    // Reset mid-stream with a beat in the output stage
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd9};
    req_data  = {32'd0, 32'd0, 32'h99};
    tick();
    req_valid = 3'b000;
    check("mid_wr_en", {31'd0, rf_wr_en}, 32'd1);
    check("mid_addr",  {27'd0, rf_wr_addr}, 32'd9);
    nrst = 1'b0;
    tick();
    check("mid_rst_en",   {31'd0, rf_wr_en}, 32'd0);
    check("mid_rst_busy", busy_mask, 32'd0);
    check("mid_rst_x0",   {31'd0, x0_drop}, 32'd0);
    nrst      = 1'b1;
    req_valid = 3'b111;
    #1;
    check("mid_post_ready", {29'd0, req_ready}, 32'b001);
    tick();
    req_valid = 3'b000;
    check("mid_post_src", {29'd0, rf_wr_src}, 32'd0);
    $display("txn midrst: beat discarded, requester 0 first");

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
